// File: rtl/rx_lane_deskew_ctrl.sv
// rtl/rx_lane_deskew_ctrl.sv - two-lane COM hunt, skew measurement and early-lane delay; RX_LANE_STATS_EN adds err_count
module rx_lane_deskew_ctrl #(
    parameter int         MAX_SKEW     = 4,
    parameter logic [7:0] COM          = 8'hBC,
    parameter int         RETRY_CYCLES = 16
`ifdef RX_LANE_STATS_EN
   ,parameter int         ERR_CNT_W    = 8
`endif
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       active_serial_paralelo_0,
    input  logic       active_serial_paralelo_1,
    input  logic       valid_serial_paralelo_0,
    input  logic       valid_serial_paralelo_1,
    input  logic [7:0] data_serial_paralelo_0,
    input  logic [7:0] data_serial_paralelo_1,
    output logic [7:0] data_aligned_0,
    output logic [7:0] data_aligned_1,
    output logic       valid_aligned,
    output logic       link_up,
    output logic [2:0] skew,
    output logic       skew_lane,
    output logic       align_err
`ifdef RX_LANE_STATS_EN
   ,output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam int              DL_D       = (MAX_SKEW > 0) ? MAX_SKEW : 1;
    localparam int              RW         = $clog2(RETRY_CYCLES + 1);
    localparam logic [3:0]      MAX_CNT    = 4'(MAX_SKEW);
    localparam logic [RW-1:0]   RETRY_LAST = RW'(RETRY_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HUNT, LINKED, ERROR} state_t;

    state_t        state, state_nx;
    logic          hunt_armed, hunt_armed_nx, hunt_lane, hunt_lane_nx;
    logic [3:0]    hunt_cnt, hunt_cnt_nx;
    logic [RW-1:0] retry_cnt, retry_cnt_nx;
    logic [2:0]    skew_nx;
    logic          skew_lane_nx;
    logic [8:0]    dl [DL_D];
    logic [8:0]    lane_0, lane_1, early_in, early_out, tap, pre_0, pre_1, out_0, out_1;
    logic          com_0, com_1, acom_0, acom_1, late_com, early_com, lanes_ok, keep;

    assign lane_0    = {valid_serial_paralelo_0, data_serial_paralelo_0};
    assign lane_1    = {valid_serial_paralelo_1, data_serial_paralelo_1};
    assign com_0     = lane_0[8] && (lane_0[7:0] == COM);
    assign com_1     = lane_1[8] && (lane_1[7:0] == COM);
    assign lanes_ok  = active_serial_paralelo_0 && active_serial_paralelo_1;
    assign late_com  = hunt_lane ? com_0 : com_1;
    assign early_com = hunt_lane ? com_1 : com_0;

    // Early lane is tapped skew stages deep; the late lane bypasses the delay line.
    always_comb begin
        tap = '0;
        for (int i = 0; i < DL_D; i++) begin
            if (skew == 3'(i + 1)) tap = dl[i];
        end
    end

    assign early_in  = skew_lane ? lane_1 : lane_0;
    assign early_out = (skew == 3'd0) ? early_in : tap;
    assign pre_0     = skew_lane ? lane_0 : early_out;
    assign pre_1     = skew_lane ? early_out : lane_1;
    assign acom_0    = pre_0[8] && (pre_0[7:0] == COM);
    assign acom_1    = pre_1[8] && (pre_1[7:0] == COM);

    always_comb begin
        state_nx      = state;
        hunt_armed_nx = hunt_armed;
        hunt_lane_nx  = hunt_lane;
        hunt_cnt_nx   = hunt_cnt;
        retry_cnt_nx  = retry_cnt;
        skew_nx       = skew;
        skew_lane_nx  = skew_lane;
        case (state)
            IDLE: if (lanes_ok) state_nx = HUNT;
            HUNT: begin
                if (!hunt_armed) begin
                    if (com_0 && com_1) begin
                        state_nx     = LINKED;
                        skew_nx      = 3'd0;
                        skew_lane_nx = 1'b0;
                    end else if (com_0 || com_1) begin
                        hunt_armed_nx = 1'b1;
                        hunt_lane_nx  = com_1;
                        hunt_cnt_nx   = 4'd1;
                    end
                end else if (late_com && (hunt_cnt <= MAX_CNT)) begin
                    state_nx     = LINKED;
                    skew_nx      = hunt_cnt[2:0];
                    skew_lane_nx = hunt_lane;
                end else if (hunt_cnt > MAX_CNT) begin
                    state_nx = ERROR;
                end else if (early_com) begin
                    hunt_cnt_nx = 4'd1;
                end else begin
                    hunt_cnt_nx = hunt_cnt + 4'd1;
                end
            end
            LINKED: if (acom_0 ^ acom_1) state_nx = ERROR;
            ERROR: begin
                if (retry_cnt == RETRY_LAST) state_nx = IDLE;
                else retry_cnt_nx = retry_cnt + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        // Losing byte lock on either lane overrides everything, including a skew load.
        if (state != IDLE && !lanes_ok) begin
            state_nx     = IDLE;
            skew_nx      = skew;
            skew_lane_nx = skew_lane;
        end
        if (state_nx != HUNT) begin
            hunt_armed_nx = 1'b0;
            hunt_cnt_nx   = 4'd0;
        end
        if (state_nx != ERROR) retry_cnt_nx = '0;
    end

    assign keep = (state == LINKED) && (state_nx == LINKED);

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            hunt_armed <= 1'b0;
            hunt_lane  <= 1'b0;
            hunt_cnt   <= 4'd0;
            retry_cnt  <= '0;
            skew       <= 3'd0;
            skew_lane  <= 1'b0;
            align_err  <= 1'b0;
            out_0      <= '0;
            out_1      <= '0;
            for (int i = 0; i < DL_D; i++) dl[i] <= '0;
        end else begin
            state      <= state_nx;
            hunt_armed <= hunt_armed_nx;
            hunt_lane  <= hunt_lane_nx;
            hunt_cnt   <= hunt_cnt_nx;
            retry_cnt  <= retry_cnt_nx;
            skew       <= skew_nx;
            skew_lane  <= skew_lane_nx;
            align_err  <= (state_nx == ERROR) && (state != ERROR);
            if (keep) begin
                out_0 <= {pre_0[8], pre_0[8] ? pre_0[7:0] : 8'h00};
                out_1 <= {pre_1[8], pre_1[8] ? pre_1[7:0] : 8'h00};
                dl[0] <= early_in;
                for (int i = 1; i < DL_D; i++) dl[i] <= dl[i-1];
            end else begin
                out_0 <= '0;
                out_1 <= '0;
                for (int i = 0; i < DL_D; i++) dl[i] <= '0;
            end
        end
    end

`ifdef RX_LANE_STATS_EN
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if ((state_nx == ERROR) && (state != ERROR) && !(&err_count)) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

    assign data_aligned_0 = out_0[7:0];
    assign data_aligned_1 = out_1[7:0];
    assign valid_aligned  = out_0[8] & out_1[8];
    assign link_up        = (state == LINKED);

endmodule

// File: tb/tb_rx_lane_deskew_ctrl.sv
// tb/tb_rx_lane_deskew_ctrl.sv - directed bench for rx_lane_deskew_ctrl
module tb_rx_lane_deskew_ctrl;

    localparam logic [7:0] COM = 8'hBC;

    logic       clk_4f = 1'b0;
    logic       reset;
    logic       act_0, act_1, v_0, v_1;
    logic [7:0] d_0, d_1;
    logic [7:0] data_aligned_0, data_aligned_1;
    logic       valid_aligned, link_up, skew_lane, align_err;
    logic [2:0] skew;
`ifdef RX_LANE_STATS_EN
    logic [7:0] err_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    rx_lane_deskew_ctrl dut (
        .clk_4f                   (clk_4f),
        .reset                    (reset),
        .active_serial_paralelo_0 (act_0),
        .active_serial_paralelo_1 (act_1),
        .valid_serial_paralelo_0  (v_0),
        .valid_serial_paralelo_1  (v_1),
        .data_serial_paralelo_0   (d_0),
        .data_serial_paralelo_1   (d_1),
        .data_aligned_0           (data_aligned_0),
        .data_aligned_1           (data_aligned_1),
        .valid_aligned            (valid_aligned),
        .link_up                  (link_up),
        .skew                     (skew),
        .skew_lane                (skew_lane),
        .align_err                (align_err)
`ifdef RX_LANE_STATS_EN
       ,.err_count                (err_count)
`endif
    );

    always #5 clk_4f = ~clk_4f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic lanes(input logic a0, input logic a1, input logic vv0, input logic vv1,
                         input logic [7:0] b0, input logic [7:0] b1);
        act_0 = a0; act_1 = a1; v_0 = vv0; v_1 = vv1; d_0 = b0; d_1 = b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_link"}, 32'(link_up), 0);
        check({tag, "_valid"}, 32'(valid_aligned), 0);
        check({tag, "_skew"}, 32'(skew), 0);
        check({tag, "_lane"}, 32'(skew_lane), 0);
        check({tag, "_err"}, 32'(align_err), 0);
        check({tag, "_d0"}, 32'(data_aligned_0), 0);
        check({tag, "_d1"}, 32'(data_aligned_1), 0);
    endtask

    initial begin
        reset = 1'b0;
        lanes(0, 0, 0, 0, 8'h00, 8'h00);
        #12;
        check_all_zero("rst");
`ifdef RX_LANE_STATS_EN
        check("rst_cnt", 32'(err_count), 0);
`endif
        reset = 1'b1;

        // Same-cycle COM: zero skew, data one cycle behind.
        lanes(1, 1, 0, 0, 8'h00, 8'h00); tick;
        lanes(1, 1, 1, 1, COM, COM); tick;
        check("t1_link", 32'(link_up), 1);
        check("t1_skew", 32'(skew), 0);
        check("t1_valid0", 32'(valid_aligned), 0);
        lanes(1, 1, 1, 1, 8'h11, 8'h22); tick;
        check("t1_d0", 32'(data_aligned_0), 32'h11);
        check("t1_d1", 32'(data_aligned_1), 32'h22);
        check("t1_valid", 32'(valid_aligned), 1);

        // Lock loss drops straight to IDLE without an alignment error.
        lanes(0, 1, 1, 1, 8'h11, 8'h22); tick;
        check("t4_link", 32'(link_up), 0);
        check("t4_valid", 32'(valid_aligned), 0);
        check("t4_err", 32'(align_err), 0);

        // Lane 1 COM three cycles ahead of lane 0.
        lanes(1, 1, 0, 0, 8'h00, 8'h00); tick;
        lanes(1, 1, 1, 1, 8'h00, COM); tick;
        lanes(1, 1, 1, 1, 8'h00, 8'h00); tick; tick;
        lanes(1, 1, 1, 1, COM, 8'h00); tick;
        check("t2_link", 32'(link_up), 1);
        check("t2_skew", 32'(skew), 3);
        check("t2_lane", 32'(skew_lane), 1);
        for (int c = 0; c < 10; c++) begin
            lanes(1, 1, c >= 3, 1, (c >= 3) ? 8'(8'hA0 + c - 3) : 8'h00, 8'(8'hA0 + c));
            tick;
            check("t2_valid", 32'(c >= 3), 32'(valid_aligned));
            if (c >= 3) begin
                check("t2_d0", 32'(data_aligned_0), 32'(8'hA0 + c - 3));
                check("t2_d1", 32'(data_aligned_1), 32'(8'hA0 + c - 3));
            end
        end

        // Skew 2, then a lone COM on lane 1 trips the post-delay check.
        lanes(1, 0, 0, 0, 8'h00, 8'h00); tick;
        check("t5_idle_link", 32'(link_up), 0);
        lanes(1, 1, 0, 0, 8'h00, 8'h00); tick;
        lanes(1, 1, 1, 1, 8'h00, COM); tick;
        lanes(1, 1, 1, 1, 8'h00, 8'h00); tick;
        lanes(1, 1, 1, 1, COM, 8'h00); tick;
        check("t5_skew", 32'(skew), 2);
        check("t5_lane", 32'(skew_lane), 1);
        for (int c = 0; c < 7; c++) begin
            lanes(1, 1, c >= 2, 1, (c >= 2) ? 8'(8'hB0 + c - 2) : 8'h00,
                  (c == 4) ? COM : 8'(8'hB0 + c));
            tick;
            check("t5_err", 32'(align_err), 32'(c == 6));
            check("t5_link", 32'(link_up), 32'(c != 6));
            check("t5_valid", 32'(valid_aligned), 32'(c >= 2 && c < 6));
            if (c >= 2 && c < 6) check("t5_d1", 32'(data_aligned_1), 32'(8'hB0 + c - 2));
        end
        tick;
        check("t5_pulse", 32'(align_err), 0);
        check("t5_hold_skew", 32'(skew), 2);
`ifdef RX_LANE_STATS_EN
        check("t5_cnt", 32'(err_count), 1);
`endif
        lanes(0, 1, 0, 0, 8'h00, 8'h00); tick;
        check("t5_exit_err", 32'(align_err), 0);

        // Late lane never shows: ERROR after the counter passes MAX_SKEW, then retry.
        lanes(1, 1, 0, 0, 8'h00, 8'h00); tick;
        lanes(1, 1, 1, 1, COM, 8'h00); tick;
        lanes(1, 1, 1, 1, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) begin
            tick;
            check("t3_no_err", 32'(align_err), 0);
        end
        tick;
        check("t3_err", 32'(align_err), 1);
        check("t3_link", 32'(link_up), 0);
        lanes(1, 1, 1, 1, COM, COM);
        for (int k = 1; k <= 18; k++) begin
            tick;
            check("t3_retry_link", 32'(link_up), 32'(k == 18));
            if (k == 1) begin
                check("t3_pulse", 32'(align_err), 0);
                check("t3_hold_skew", 32'(skew), 2);
            end
        end
        check("t3_skew", 32'(skew), 0);
`ifdef RX_LANE_STATS_EN
        check("t3_cnt", 32'(err_count), 2);
`endif

        // Asynchronous reset mid-LINKED.
        lanes(1, 1, 1, 1, 8'h33, 8'h44); tick;
        check("t6_valid", 32'(valid_aligned), 1);
        check("t6_d0", 32'(data_aligned_0), 32'h33);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("t6_rst");
        #2;
        reset = 1'b1;
        lanes(1, 1, 0, 0, 8'h00, 8'h00); tick;
        check("t6_idle_link", 32'(link_up), 0);
        lanes(1, 1, 1, 1, COM, COM); tick;
        check("t6_relink", 32'(link_up), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
